chunked_adder: RTL

Parametrised multi-cycle ripple adder and the sequential successor to the combinational full adder. It adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock. It uses a start/busy/done handshake and holds the result in registers. It sits between operand registers and result consumers wherever a wide adder must trade latency for a shorter carry chain.

---
 rtl/chunked_adder_if.sv | 14 +
 rtl/chunked_adder.sv | 71 +++++++
 2 files changed

// File: rtl/chunked_adder_if.sv
// chunked_adder_if: start/busy/done handshake, operands and registered result of chunked_adder.
// With CHUNKED_ADDER_OVF_EN defined the bundle also carries the signed overflow flag ovf.
interface chunked_adder_if #(parameter int WIDTH = 8) ();
  logic start, cin, busy, done, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CHUNKED_ADDER_OVF_EN
  logic ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple adder, CHUNK bits per clock, carry held in a register between chunks.
// Optional macro CHUNKED_ADDER_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst_n,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_next;
  logic [IW-1:0] idx;
  logic carry;
  logic [CHUNK:0] csum;
  always_comb begin
    csum = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
    acc_next = acc;
    acc_next[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      bus.ovf <= 1'b0;
`endif
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      idx <= '0;
      carry <= 1'b0;
    end else
      case (state)
        RUN: begin
          acc <= acc_next;
          carry <= csum[CHUNK];
          if (idx == LAST) begin
            bus.sum <= acc_next;
            bus.cout <= csum[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
            bus.ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_next[WIDTH-1] != a_r[WIDTH-1]);
`endif
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state <= DONE;
          end else
            idx <= idx + 1'b1;
        end
        default: begin
          // DONE accepts a new start exactly like IDLE, giving back-to-back operation
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r <= bus.a;
            b_r <= bus.b;
            carry <= bus.cin;
            idx <= '0;
            bus.busy <= 1'b1;
            state <= RUN;
          end else
            state <= IDLE;
        end
      endcase
endmodule
